// File: rtl/spi_pkg.sv
// Shared SPI types and constants for the mode-0 master and its companion slaves.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package spi_pkg;

  // Frame shape: 8-bit frames, clock idles low (mode 0).
  localparam int SPI_BITS = 8;
  localparam bit SPI_CPOL = 1'b0;

  // CLK_DIV legality. CDC-synchronised slaves need at least 4 sysClk per half-period.
  localparam int CLK_DIV_MIN     = 2;
  localparam int CLK_DIV_MAX     = 255;
  localparam int CLK_DIV_CDC_MIN = 4;

  // Phase lengths for setup/hold must fit the 8-bit phase timer (count-1 is loaded).
  localparam int PHASE_MIN = 1;
  localparam int PHASE_MAX = 256;

  // Companion CDC-synchronised slave state encoding.
  typedef enum logic [1:0] {
    SIdle,
    SShift,
    SDone
  } SlaveState;

  // Master sequencing states.
  typedef enum logic [2:0] {
    MIdle,
    MCsSetup,
    MLow,
    MHigh,
    MCsHold,
    MGap
  } MasterState;

  function automatic bit clk_div_legal(input int div);
    return (div >= CLK_DIV_MIN) && (div <= CLK_DIV_MAX);
  endfunction

  function automatic bit phase_legal(input int len);
    return (len >= PHASE_MIN) && (len <= PHASE_MAX);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// 8-bit loadable down-counter timing one master phase (setup, half-period, hold, gap).
// Latency: done_o reflects the registered count; load takes effect on the next edge.
// Backpressure: none; the counter parks at zero until reloaded.
module spi_phase_timer (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       count_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  // Load wins over counting; counting stops at zero so an unreloaded timer stays done.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, 8-bit frames, optional /CS hold across bytes.
// Latency: accept at T -> cs low T+1, rx_valid at T+1+CS_SETUP+16*CLK_DIV (T+1+16*CLK_DIV if held).
// Backpressure: ready=1 only in MIdle; start while ready=0 is dropped, nothing is queued.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                sysClk,
  input  logic                reset,
  input  logic                start,
  input  logic                hold_cs,
  input  logic [SPI_BITS-1:0] tx_byte,
  output logic                ready,
  output logic                rx_valid,
  output logic [SPI_BITS-1:0] rx_byte,
  output logic                spiClk,
  output logic                cs,
  output logic                mosi,
  input  logic                miso
);

  // Reject illegal timing parameters at elaboration.
  if (!clk_div_legal(CLK_DIV) || !phase_legal(CS_SETUP) || !phase_legal(CS_HOLD)) begin : g_bad_param
    $error("spi_master: CLK_DIV must be 2..255, CS_SETUP/CS_HOLD 1..256");
  end

  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);

  MasterState          state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-2:0] tx_rest_q, tx_rest_d;   // bits still to send after the one on mosi
  logic [SPI_BITS-2:0] rx_sh_q, rx_sh_d;       // bits received so far in this byte
  logic                hold_q, hold_d;
  logic                spi_clk_q, spi_clk_d;
  logic                cs_q, cs_d;
  logic                mosi_q, mosi_d;
  logic                rx_valid_q, rx_valid_d;
  logic [SPI_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                miso_q;
  logic [SPI_BITS-1:0] rx_next;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  spi_phase_timer u_timer (
    .clk_i      (sysClk),
    .reset_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (!tmr_load),
    .done_o     (tmr_done)
  );

  // Next-state and output logic: each state is entered with its timer loaded to length-1.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_rest_d  = tx_rest_q;
    rx_sh_d    = rx_sh_q;
    hold_d     = hold_q;
    spi_clk_d  = spi_clk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    tmr_load   = 1'b0;
    tmr_val    = DIV_LD;
    rx_next    = {rx_sh_q, miso_q};

    case (state_q)
      MIdle: begin
        if (start) begin
          tx_rest_d = tx_byte[SPI_BITS-2:0];
          mosi_d    = tx_byte[SPI_BITS-1];
          hold_d    = hold_cs;
          bit_cnt_d = 3'd7;
          tmr_load  = 1'b1;
          if (cs_q) begin
            state_d = MCsSetup;
            cs_d    = 1'b0;
            tmr_val = SETUP_LD;
          end else begin
            // /CS still held from the previous byte: no setup phase needed.
            state_d = MLow;
          end
        end
      end
      MCsSetup: begin
        if (tmr_done) begin
          state_d  = MLow;
          tmr_load = 1'b1;
        end
      end
      MLow: begin
        if (tmr_done) begin
          state_d   = MHigh;
          spi_clk_d = 1'b1;
          tmr_load  = 1'b1;
        end
      end
      MHigh: begin
        if (tmr_done) begin
          // Sample at the very end of the high phase to absorb slave synchroniser delay.
          rx_sh_d   = rx_next[SPI_BITS-2:0];
          spi_clk_d = 1'b0;
          tmr_load  = 1'b1;
          if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            mosi_d    = tx_rest_q[SPI_BITS-2];
            tx_rest_d = {tx_rest_q[SPI_BITS-3:0], 1'b0};
            state_d   = MLow;
          end else begin
            rx_byte_d  = rx_next;
            rx_valid_d = 1'b1;
            if (hold_q) begin
              state_d = MIdle;
            end else begin
              state_d = MCsHold;
              tmr_val = HOLD_LD;
            end
          end
        end
      end
      MCsHold: begin
        if (tmr_done) begin
          cs_d     = 1'b1;
          state_d  = MGap;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      MGap: begin
        if (tmr_done) begin
          state_d = MIdle;
        end
      end
      default: state_d = MIdle;
    endcase
  end

  // State and datapath registers with synchronous reset; miso gets one register stage.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q    <= MIdle;
      bit_cnt_q  <= 3'd7;
      tx_rest_q  <= '0;
      rx_sh_q    <= '0;
      hold_q     <= 1'b0;
      spi_clk_q  <= SPI_CPOL;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_rest_q  <= tx_rest_d;
      rx_sh_q    <= rx_sh_d;
      hold_q     <= hold_d;
      spi_clk_q  <= spi_clk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      miso_q     <= miso;
    end
  end

  assign ready    = (state_q == MIdle);
  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;
  assign spiClk   = spi_clk_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master against a transaction-level reference model.
// Latency: expectations derived from the documented cycle formulas per transaction.
// Backpressure: bytes issued only when ready; busy-time starts must be ignored.
module tb_spi_master;

  localparam int DIV = 4, SETUP = 2, HOLD = 2;
  localparam int MODE_LOOP = 0, MODE_ONE = 1, MODE_ZERO = 2, MODE_RESP = 3;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic       reset = 1'b1, start = 1'b0, hold_cs = 1'b0, miso;
  logic [7:0] tx_byte = 8'h00, rx_byte;
  logic       ready, rx_valid, spiClk, cs, mosi;

  spi_master #(.CLK_DIV(DIV), .CS_SETUP(SETUP), .CS_HOLD(HOLD)) dut (
    .sysClk(sysClk), .reset(reset), .start(start), .hold_cs(hold_cs), .tx_byte(tx_byte),
    .ready(ready), .rx_valid(rx_valid), .rx_byte(rx_byte), .spiClk(spiClk), .cs(cs),
    .mosi(mosi), .miso(miso)
  );

  // Second instance for the fast-clock timing case, in loopback.
  logic       reset2 = 1'b1, start2 = 1'b0, hold2 = 1'b0;
  logic [7:0] tx2 = 8'h00, rx2;
  logic       ready2, rxv2, clk2, cs2, mosi2;

  spi_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(2)) dut2 (
    .sysClk(sysClk), .reset(reset2), .start(start2), .hold_cs(hold2), .tx_byte(tx2),
    .ready(ready2), .rx_valid(rxv2), .rx_byte(rx2), .spiClk(clk2), .cs(cs2),
    .mosi(mosi2), .miso(mosi2)
  );

  int cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- slave model and bus monitor ----------------
  int         mode = MODE_LOOP;
  logic [7:0] tx_list[8];
  logic [7:0] resp[8];
  int         fall_cnt = 0;
  logic       slave_bit = 1'b0;
  logic [7:0] cur;

  always_comb begin
    case (mode)
      MODE_LOOP: miso = mosi;
      MODE_ONE:  miso = 1'b1;
      MODE_ZERO: miso = 1'b0;
      default:   miso = slave_bit;
    endcase
  end

  int   rises = 0, cs_falls = 0, cs_rises = 0, mosi_bad = 0;
  int   cs_fall_t = -1, cs_rise_t = -1, ready_rise_t = -1;
  int   rise_t[$];
  logic mosi_bits[$];
  logic [7:0] rx_q[$];
  int   rv_t[$];
  logic p_clk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_ready = 1'b1;

  always @(negedge sysClk) begin
    if (spiClk && !p_clk) begin
      rises++;
      rise_t.push_back(cyc);
      mosi_bits.push_back(mosi);
    end
    if (!spiClk && p_clk) fall_cnt++;
    if (spiClk && (mosi !== p_mosi)) mosi_bad++;
    if (!cs && p_cs) begin
      cs_falls++;
      cs_fall_t = cyc;
      fall_cnt  = 0;
    end
    if (cs && !p_cs) begin
      cs_rises++;
      cs_rise_t = cyc;
    end
    if (ready && !p_ready) ready_rise_t = cyc;
    if (rx_valid) begin
      rx_q.push_back(rx_byte);
      rv_t.push_back(cyc);
    end
    // Response slave shifts a new bit out after each falling spiClk edge.
    cur       = resp[(fall_cnt / 8) % 8];
    slave_bit = cur[7 - (fall_cnt % 8)];
    p_clk = spiClk; p_cs = cs; p_mosi = mosi; p_ready = ready;
  end

  int cs2_fall_t = -1, rise2_t = -1, rv2_t = -1;
  logic [7:0] rx2_got = 8'h00;
  logic p_cs2 = 1'b1, p_clk2 = 1'b0;

  always @(negedge sysClk) begin
    if (!cs2 && p_cs2 && cs2_fall_t < 0) cs2_fall_t = cyc;
    if (clk2 && !p_clk2 && rise2_t < 0) rise2_t = cyc;
    if (rxv2 && rv2_t < 0) begin
      rv2_t   = cyc;
      rx2_got = rx2;
    end
    p_cs2 = cs2; p_clk2 = clk2;
  end

  task automatic clear_mon();
    @(negedge sysClk);
    rises = 0; cs_falls = 0; cs_rises = 0; mosi_bad = 0;
    cs_fall_t = -1; cs_rise_t = -1; ready_rise_t = -1;
    rise_t.delete(); mosi_bits.delete(); rx_q.delete(); rv_t.delete();
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready && k < 2000) begin
      @(negedge sysClk);
      k++;
    end
    if (!ready) tb_check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // One /CS transaction of n bytes (all but the last held), checked against the model.
  task automatic run_txn(input string name, input int n, input int md, input bit poke);
    int t_acc[8];
    int k, errs;
    logic [7:0] exp_b, mb;
    clear_mon();
    mode = md;
    for (int i = 0; i < n; i++) begin
      wait_ready(name);
      start = 1'b1; tx_byte = tx_list[i]; hold_cs = (i < n - 1);
      t_acc[i] = cyc;
      @(negedge sysClk);
      start = 1'b0; tx_byte = 8'($urandom); hold_cs = 1'($urandom);
      if (poke && i == 0) begin
        repeat ($urandom_range(2, 30)) @(negedge sysClk);
        tb_check({name, "_busy_ready"}, 32'(ready), 32'd0);
        start = 1'b1; tx_byte = 8'h3C; hold_cs = 1'b1;
        @(negedge sysClk);
        start = 1'b0;
      end
      k = 0;
      while (rx_q.size() <= i && k < 5000) begin
        @(negedge sysClk);
        k++;
      end
      if (rx_q.size() <= i) tb_check($sformatf("%s_rx%0d_timeout", name, i), 32'd0, 32'd1);
      if (i < n - 1) repeat ($urandom_range(0, 4)) @(negedge sysClk);
    end
    wait_ready(name);
    repeat (2 * HOLD + 4) @(negedge sysClk);

    tb_check({name, "_rx_count"}, 32'(rx_q.size()), 32'(n));
    tb_check({name, "_rises"}, 32'(rises), 32'(8 * n));
    tb_check({name, "_cs_falls"}, 32'(cs_falls), 32'd1);
    tb_check({name, "_cs_rises"}, 32'(cs_rises), 32'd1);
    tb_check({name, "_mosi_change_hi"}, 32'(mosi_bad), 32'd0);
    if (rx_q.size() == n && rise_t.size() == 8 * n) begin
      errs = 0;
      for (int i = 0; i < n; i++) begin
        case (md)
          MODE_LOOP: exp_b = tx_list[i];
          MODE_ONE:  exp_b = 8'hFF;
          MODE_ZERO: exp_b = 8'h00;
          default:   exp_b = resp[i];
        endcase
        tb_check($sformatf("%s_rx%0d", name, i), 32'(rx_q[i]), 32'(exp_b));
        mb = 8'h00;
        for (int j = 0; j < 8; j++) mb = {mb[6:0], mosi_bits[8 * i + j]};
        tb_check($sformatf("%s_mosi%0d", name, i), 32'(mb), 32'(tx_list[i]));
        tb_check($sformatf("%s_rise0_b%0d", name, i), 32'(rise_t[8 * i]),
                 32'(t_acc[i] + 1 + ((i == 0) ? SETUP : 0) + DIV));
        tb_check($sformatf("%s_rv_t%0d", name, i), 32'(rv_t[i]),
                 32'(t_acc[i] + 1 + ((i == 0) ? SETUP : 0) + 16 * DIV));
        for (int j = 0; j < 7; j++)
          if (rise_t[8 * i + j + 1] - rise_t[8 * i + j] != 2 * DIV) errs++;
      end
      tb_check({name, "_rise_spacing"}, 32'(errs), 32'd0);
      tb_check({name, "_cs_fall_t"}, 32'(cs_fall_t), 32'(t_acc[0] + 1));
      tb_check({name, "_cs_rise_t"}, 32'(cs_rise_t), 32'(rv_t[n - 1] + HOLD));
      tb_check({name, "_ready_t"}, 32'(ready_rise_t), 32'(rv_t[n - 1] + 2 * HOLD));
    end
  endtask

  initial begin
    int k, base, n, md;

    // Reset values, both while held and just after release.
    repeat (3) @(negedge sysClk);
    tb_check("rst_cs", 32'(cs), 32'd1);
    tb_check("rst_spiclk", 32'(spiClk), 32'd0);
    tb_check("rst_mosi", 32'(mosi), 32'd0);
    tb_check("rst_ready", 32'(ready), 32'd1);
    tb_check("rst_rxv", 32'(rx_valid), 32'd0);
    tb_check("rst_rxbyte", 32'(rx_byte), 32'd0);
    reset = 1'b0;
    @(negedge sysClk);
    tb_check("post_rst_ready", 32'(ready), 32'd1);

    tx_list[0] = 8'hA5;
    run_txn("lb_a5", 1, MODE_LOOP, 1'b0);
    tx_list[0] = 8'h80;
    run_txn("one_80", 1, MODE_ONE, 1'b0);
    run_txn("zero_80", 1, MODE_ZERO, 1'b0);

    tx_list[0] = 8'h41; tx_list[1] = 8'h12; tx_list[2] = 8'h00;
    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h99;
    run_txn("mcp_read", 3, MODE_RESP, 1'b0);

    tx_list[0] = 8'hC6;
    run_txn("busy_start", 1, MODE_LOOP, 1'b1);

    // Reset partway through a byte.
    clear_mon();
    mode = MODE_LOOP;
    wait_ready("midrst");
    start = 1'b1; tx_byte = 8'hC3; hold_cs = 1'b0;
    @(negedge sysClk);
    start = 1'b0;
    k = 0;
    while (rises < 4 && k < 2000) begin
      @(negedge sysClk);
      k++;
    end
    tb_check("midrst_reach_bit4", 32'(rises), 32'd4);
    repeat (2) @(negedge sysClk);
    reset = 1'b1;
    @(negedge sysClk);
    tb_check("midrst_cs", 32'(cs), 32'd1);
    tb_check("midrst_spiclk", 32'(spiClk), 32'd0);
    tb_check("midrst_ready", 32'(ready), 32'd1);
    tb_check("midrst_rxv", 32'(rx_valid), 32'd0);
    tb_check("midrst_rxbyte", 32'(rx_byte), 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge sysClk);
    tb_check("midrst_no_rxv", 32'(rx_q.size()), 32'd0);
    tx_list[0] = 8'h5A;
    run_txn("post_rst_5a", 1, MODE_LOOP, 1'b0);

    // Randomised transactions.
    for (int r = 0; r < 16; r++) begin
      n  = $urandom_range(1, 3);
      md = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) begin
        tx_list[i] = 8'($urandom);
        resp[i]    = 8'($urandom);
      end
      run_txn($sformatf("rnd%0d", r), n, md, 1'($urandom));
    end

    // Fast divider, short setup: fixed absolute timing from a known base.
    @(negedge sysClk);
    reset2 = 1'b0;
    base = cyc;
    while (cyc < base + 10) @(negedge sysClk);
    tb_check("div2_ready", 32'(ready2), 32'd1);
    start2 = 1'b1; tx2 = 8'($urandom); hold2 = 1'b0;
    @(negedge sysClk);
    start2 = 1'b0;
    k = 0;
    while (rv2_t < 0 && k < 500) begin
      @(negedge sysClk);
      k++;
    end
    tb_check("div2_cs_fall", 32'(cs2_fall_t - base), 32'd11);
    tb_check("div2_rise0", 32'(rise2_t - base), 32'd14);
    tb_check("div2_rxv", 32'(rv2_t - base), 32'd44);
    tb_check("div2_rxbyte", 32'(rx2_got), 32'(tx2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames, driving the codebase's CDC-synchronised SPI slaves and MCP23S17-style IO expanders.
- Generates spiClk, /CS and MOSI from sysClk and samples MISO.
- Multi-byte transactions keep /CS asserted between bytes, under control of the byte issuer (CPU IO port or test sequencer).

Parameters:
- CLK_DIV, 4: sysClk cycles per spiClk half-period. Legal range is 2..255. Must be ≥4 when the far end is a CDC-synchronised slave.
- CS_SETUP, 2: sysClk cycles from /CS fall to the start of the first low phase.
- CS_HOLD, 2: sysClk cycles /CS stays low after the last falling spiClk edge. The same value is the minimum /CS-high gap before the next transaction.

Ports:
- sysClk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  byte request, accepted only when ready=1.
- hold_cs  in  1  sampled with start; 1 keeps /CS low after this byte.
- tx_byte  in  8  byte to send, sampled with start.
- ready  out  1  1 when a start is accepted this cycle.
- rx_valid  out  1  one-cycle pulse when rx_byte has been updated.
- rx_byte  out  8  last byte received; holds its value until the next update.
- spiClk  out  1  SPI clock to the slave; idles low.
- cs  out  1  /CS, active low.
- mosi  out  1  serial data to the slave.
- miso  in  1  serial data from the slave; registered once before use.

Behaviour:
- Reset: synchronous and active-high. Clock is sysClk. Reset outputs are spiClk=0, cs=1, mosi=0, ready=1, rx_valid=0, rx_byte=8'h00, state=MIdle, bitCnt=7.
- Reset mid-byte: the block returns to reset values on the next edge, so cs=1 one cycle after reset is asserted. No rx_valid is produced.
- Accept: start&ready latches tx_byte into the shift register and latches hold_cs. ready drops on the next cycle.
- start while ready=0 is ignored, with no queuing.
- States are MIdle, MCsSetup, MLow, MHigh, MCsHold, MGap.
- Counting: a phase counter is loaded with (count−1) on state entry and the state exits when the counter reaches 0.
- MIdle + accept with cs=1: go to MCsSetup. Drive cs=0 and mosi=tx[7]. Stay CS_SETUP cycles.
- MIdle + accept with cs already 0 (held): go directly to MLow with mosi=tx[7].
- MLow: spiClk=0 for CLK_DIV cycles, then go to MHigh (spiClk rises).
- MHigh: spiClk=1 for CLK_DIV cycles.
  - In the last MHigh cycle, shift registered miso into the receive register LSB.
  - Sampling at the end of the high phase absorbs the slave synchroniser latency.
- Exit from MHigh with bitCnt≠0: decrement bitCnt, shift the next bit onto mosi simultaneously with the spiClk fall, and go to MLow.
- Exit from MHigh with bitCnt=0:
  - spiClk=0, rx_byte is loaded, and rx_valid pulses in the same cycle.
  - If hold_cs was latched: go to MIdle with cs=0 and ready=1.
  - Otherwise: go to MCsHold for CS_HOLD cycles, then cs=1, then MGap for CS_HOLD cycles, then MIdle with ready=1.
- Held-CS idle: spiClk=0, mosi holds its last bit, cs=0 for an unbounded time. The transaction ends only with a byte issued with hold_cs=0.
- Timing with accept at cycle T from cs=1:
  - cs=0 at T+1.
  - First spiClk rise at T+1+CS_SETUP+CLK_DIV.
  - Rises are spaced 2·CLK_DIV cycles apart.
  - rx_valid at T+1+CS_SETUP+16·CLK_DIV.
- bitCnt is 3 bits and counts down 7..0. It is reloaded to 7 on every accept, with no wrap beyond a byte.

Decomposition:
- spi_pkg holds:
  - the MasterState enum (next to the existing slave state enum);
  - localparams SPI_BITS=8 and SPI_CPOL=0;
  - CLK_DIV legality check constants.
- One sub-module, spi_phase_timer: an 8-bit loadable down-counter with load, count and done. It is reused for the setup, half-period, hold and gap phases.

Test Plan:
- Loopback (miso=mosi), CLK_DIV=4, send 8'hA5 with hold_cs=0 → rx_byte=8'hA5, one rx_valid pulse, 8 spiClk rises spaced 8 cycles, cs high again ≥2 cycles before ready.
- miso tied 1, then tied 0 → rx_byte=8'hFF, then 8'h00. mosi bit order for 8'h80 is 1,0,0,0,0,0,0,0, changing only while spiClk=0.
- MCP23S17 read 8'h41, 8'h12, 8'h00 with hold_cs=1,1,0 against a slave model returning 8'h99 in byte 3:
  - exactly one cs fall and one cs rise;
  - 24 spiClk rises;
  - rx_byte=8'h99 on the third rx_valid.
- start pulsed while ready=0 mid-byte with tx_byte=8'h3C → ignored; the first byte completes unchanged and no extra spiClk edges appear.
- reset asserted during bit 4 → next cycle cs=1, spiClk=0, ready=1, rx_valid=0, rx_byte=8'h00; a subsequent 8'h5A loopback is correct.
- CLK_DIV=2, CS_SETUP=1 with accept at cycle 10 → cs=0 at 11, first spiClk rise at 14, rx_valid at 44.
